// File: rtl/tilelink_host_pkg.sv
// Shared TileLink-UL types for bus masters and responders.
//   tilelink_a    : A-channel beat (host -> responder)
//   tilelink_d    : D-channel beat (responder -> host)
//   TL_* opcodes  : A-channel and D-channel opcode encodings
//   host_state_e  : tilelink_host control states
package tilelink_host_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    WAIT_D = 2'd2,
    RESP   = 2'd3
  } host_state_e;

endpackage

// File: rtl/tilelink_host_lane_align.sv
// Combinational byte-lane helper for 32-bit TileLink masters.
//   addr[1:0], size : access offset and log2 byte count (3 is illegal)
//   wdata           : right-aligned store data
//   rdata_raw       : full-width D-channel data
//   mask            : A-channel byte mask
//   wdata_placed    : store data shifted onto its byte lanes
//   rdata           : load data shifted down and zero-extended to size
//   misaligned      : access does not fit its natural alignment
module tl_lane_align (
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  mask,
  output logic [31:0] wdata_placed,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mask         = 4'h0;
    misaligned   = 1'b0;
    rdata        = '0;
    wdata_placed = wdata << {addr, 3'b000};
    shifted      = rdata_raw >> {addr, 3'b000};
    case (size)
      2'd0: begin
        mask  = 4'b0001 << addr;
        rdata = {24'h0, shifted[7:0]};
      end
      2'd1: begin
        mask       = 4'b0011 << {addr[1], 1'b0};
        rdata      = {16'h0, shifted[15:0]};
        misaligned = addr[0];
      end
      2'd2: begin
        mask       = 4'hF;
        rdata      = shifted;
        misaligned = (addr != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/tilelink_host.sv
// Single-outstanding TileLink-UL initiator.
//   clock, reset        : clock and synchronous active-high reset
//   req_*               : CPU-side load/store request (valid/ready)
//   rsp_*               : one-cycle response pulse with data and error
//   tla, tl_a_ready     : A-channel beat out and responder ready in
//   tld, tl_d_ready     : D-channel beat in and host ready out
module tilelink_host
  import tilelink_host_pkg::*;
#(
  parameter logic [7:0] SOURCE_ID = 8'd0,
  parameter int         TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output tilelink_a   tla,
  input  logic        tl_a_ready,
  input  tilelink_d   tld,
  output logic        tl_d_ready
);

  // Timeout fires on the TIMEOUT-th WAIT_D cycle (counter starts at 0).
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  host_state_e state, state_next;

  logic [2:0]  opcode_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  mask_q;
  logic [31:0] data_q;
  logic [7:0]  source_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic        hold_q;   // misaligned reject: spend one silent cycle in RESP

  logic [1:0]  lane_addr, lane_size;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, lane_rdata;
  logic        lane_misaligned;

  // The aligner sees the live request in IDLE and the latched one afterwards.
  assign lane_addr = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign lane_size = (state == IDLE) ? req_size      : size_q;

  tl_lane_align u_align (
    .addr         (lane_addr),
    .size         (lane_size),
    .wdata        (req_wdata),
    .rdata_raw    (tld.d_data),
    .mask         (lane_mask),
    .wdata_placed (lane_wdata),
    .rdata        (lane_rdata),
    .misaligned   (lane_misaligned)
  );

  logic is_load, d_match, d_bad, timed_out;
  assign is_load   = (opcode_q == TL_GET);
  assign d_match   = (state == WAIT_D) && tld.d_valid && (tld.d_source == SOURCE_ID);
  assign d_bad     = tld.d_error || (tld.d_opcode != (is_load ? TL_ACK_DATA : TL_ACK));
  assign timed_out = (state == WAIT_D) && (cnt_q == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = lane_misaligned ? RESP : SEND_A;
      SEND_A:  if (tl_a_ready) state_next = WAIT_D;
      WAIT_D:  if (d_match || timed_out) state_next = RESP;
      RESP:    state_next = hold_q ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      source_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          opcode_q <= !req_write        ? TL_GET :
                      (req_size == 2'd2) ? TL_PUT_FULL : TL_PUT_PARTIAL;
          addr_q   <= req_addr;
          size_q   <= req_size;
          mask_q   <= lane_mask;
          data_q   <= lane_wdata;
          source_q <= SOURCE_ID;
          rdata_q  <= '0;
          error_q  <= lane_misaligned;
          hold_q   <= lane_misaligned;
        end
        SEND_A: if (tl_a_ready) cnt_q <= '0;
        WAIT_D: begin
          cnt_q <= cnt_q + 8'd1;
          if (d_match) begin
            error_q <= d_bad;
            rdata_q <= (is_load && !d_bad) ? lane_rdata : '0;
          end else if (timed_out) begin
            error_q <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready      = (state == IDLE);
    tl_d_ready     = (state == IDLE) || (state == WAIT_D);
    rsp_valid      = (state == RESP) && !hold_q;
    rsp_rdata      = rsp_valid ? rdata_q : '0;
    rsp_error      = rsp_valid && error_q;
    tla            = '0;
    tla.a_valid    = (state == SEND_A);
    tla.a_opcode   = opcode_q;
    tla.a_size     = size_q;
    tla.a_source   = source_q;
    tla.a_address  = addr_q;
    tla.a_mask     = mask_q;
    tla.a_data     = data_q;
  end

endmodule

// File: tb/tb_tilelink_host.sv
// Directed bench for tilelink_host: vector table plus hand-written
// sequences for timeout, same-cycle D beat and reset mid-transaction.
module tb_tilelink_host;
  import tilelink_host_pkg::*;

  localparam logic [7:0] SRC = 8'd2;

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  tilelink_a   tla;
  logic        tl_a_ready;
  tilelink_d   tld;
  logic        tl_d_ready;

  int checks   = 0;
  int failures = 0;

  tilelink_host #(.SOURCE_ID(SRC), .TIMEOUT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .tla        (tla),
    .tl_a_ready (tl_a_ready),
    .tld        (tld),
    .tl_d_ready (tl_d_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          a_delay;
    logic [31:0] d_data;
    logic [2:0]  d_opcode;
    logic        d_error;
    logic        exp_beat;
    logic [2:0]  exp_opcode;
    logic [3:0]  exp_mask;
    logic [31:0] exp_adata;
    logic [31:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clock);
    check($sformatf("v%0d req_ready idle", idx), 32'(req_ready), 32'd1);
    drive_req(v.write, v.addr, v.size, v.wdata);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (v.exp_beat) begin
      for (int k = 0; k <= v.a_delay; k++) begin
        @(negedge clock);
        check($sformatf("v%0d a_valid c%0d", idx, k), 32'(tla.a_valid), 32'd1);
        check($sformatf("v%0d a_opcode c%0d", idx, k), 32'(tla.a_opcode), 32'(v.exp_opcode));
        check($sformatf("v%0d a_mask c%0d", idx, k), 32'(tla.a_mask), 32'(v.exp_mask));
        check($sformatf("v%0d a_data c%0d", idx, k), tla.a_data, v.exp_adata);
        check($sformatf("v%0d a_address c%0d", idx, k), tla.a_address, v.addr);
        check($sformatf("v%0d a_size c%0d", idx, k), 32'(tla.a_size), 32'(v.size));
        check($sformatf("v%0d a_source c%0d", idx, k), 32'(tla.a_source), 32'(SRC));
        check($sformatf("v%0d a_param c%0d", idx, k), 32'(tla.a_param), 32'd0);
        check($sformatf("v%0d d_ready send_a c%0d", idx, k), 32'(tl_d_ready), 32'd0);
        tl_a_ready = (k == v.a_delay);
        @(posedge clock); #1;
        tl_a_ready = 1'b0;
      end
      tld = '{d_valid: 1'b1, d_opcode: v.d_opcode, d_source: SRC, d_error: v.d_error,
              d_data: v.d_data};
      @(negedge clock);
      check($sformatf("v%0d a_valid dropped", idx), 32'(tla.a_valid), 32'd0);
      check($sformatf("v%0d d_ready wait_d", idx), 32'(tl_d_ready), 32'd1);
      check($sformatf("v%0d rsp early", idx), 32'(rsp_valid), 32'd0);
      @(posedge clock); #1;
      tld = '0;
    end else begin
      @(negedge clock);
      check($sformatf("v%0d no a_valid", idx), 32'(tla.a_valid), 32'd0);
      check($sformatf("v%0d rsp early", idx), 32'(rsp_valid), 32'd0);
    end
    @(negedge clock);
    check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_error", idx), 32'(rsp_error), 32'(v.exp_error));
    check($sformatf("v%0d a_valid in resp", idx), 32'(tla.a_valid), 32'd0);
    check($sformatf("v%0d d_ready resp", idx), 32'(tl_d_ready), 32'd0);
    check($sformatf("v%0d req_ready resp", idx), 32'(req_ready), 32'd0);
    @(negedge clock);
    check($sformatf("v%0d rsp one cycle", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d req_ready back", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    //          wr    addr          sz    wdata         dly dd            dop   derr  beat  opc   mask   adata         rdata         err
    vecs[0]  = '{1'b1, 32'h0000_0104, 2'd2, 32'hDEAD_BEEF, 0, 32'h0,        3'd0, 1'b0, 1'b1, 3'd0, 4'hF, 32'hDEAD_BEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0107, 2'd0, 32'h0,         0, 32'hAABB_CCDD, 3'd1, 1'b0, 1'b1, 3'd4, 4'h8, 32'h0,         32'h0000_00AA, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0202, 2'd1, 32'h0000_1234, 5, 32'h0,        3'd0, 1'b0, 1'b1, 3'd1, 4'hC, 32'h1234_0000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0101, 2'd2, 32'h0,         0, 32'h0,        3'd0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0,         32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0102, 2'd1, 32'h0,         0, 32'hAABB_CCDD, 3'd1, 1'b0, 1'b1, 3'd4, 4'hC, 32'h0,         32'h0000_AABB, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0101, 2'd0, 32'h0000_005A, 0, 32'h0,        3'd0, 1'b0, 1'b1, 3'd1, 4'h2, 32'h0000_5A00, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0300, 2'd2, 32'h0,         1, 32'h1122_3344, 3'd1, 1'b1, 1'b1, 3'd4, 4'hF, 32'h0,         32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0304, 2'd2, 32'h0,         0, 32'h5566_7788, 3'd0, 1'b0, 1'b1, 3'd4, 4'hF, 32'h0,         32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0203, 2'd1, 32'h0000_BEEF, 0, 32'h0,        3'd0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0,         32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 2'd3, 32'h0,         0, 32'h0,        3'd0, 1'b0, 1'b0, 3'd0, 4'h0, 32'h0,         32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0000_0308, 2'd2, 32'h0,         0, 32'hCAFE_F00D, 3'd1, 1'b0, 1'b1, 3'd4, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_010C, 2'd2, 32'h0102_0304, 0, 32'h0,        3'd1, 1'b0, 1'b1, 3'd0, 4'hF, 32'h0102_0304, 32'h0,        1'b1};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    tl_a_ready = 1'b0;
    tld = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_error", 32'(rsp_error), 32'd0);
    check("reset d_ready", 32'(tl_d_ready), 32'd1);
    check("reset tla zero", 32'(tla == '0), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // D beat presented during the A handshake must wait until WAIT_D.
    @(negedge clock);
    drive_req(1'b0, 32'h0000_0500, 2'd2, 32'h0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("same-cycle a_valid", 32'(tla.a_valid), 32'd1);
    check("same-cycle d_ready send_a", 32'(tl_d_ready), 32'd0);
    tl_a_ready = 1'b1;
    tld = '{d_valid: 1'b1, d_opcode: TL_ACK_DATA, d_source: SRC, d_error: 1'b0,
            d_data: 32'h0BAD_CAFE};
    @(posedge clock); #1;
    tl_a_ready = 1'b0;
    @(negedge clock);
    check("same-cycle no early rsp", 32'(rsp_valid), 32'd0);
    check("same-cycle d_ready wait_d", 32'(tl_d_ready), 32'd1);
    @(posedge clock); #1;
    tld = '0;
    @(negedge clock);
    check("same-cycle rsp_valid", 32'(rsp_valid), 32'd1);
    check("same-cycle rsp_rdata", rsp_rdata, 32'h0BAD_CAFE);
    check("same-cycle rsp_error", 32'(rsp_error), 32'd0);

    // Silent responder: error after 4 WAIT_D cycles, late beat drained in IDLE.
    @(negedge clock);
    drive_req(1'b0, 32'h0000_0400, 2'd2, 32'h0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    tl_a_ready = 1'b1;
    @(posedge clock); #1;
    tl_a_ready = 1'b0;
    seen = 0;
    for (int c = 2; c < 20 && seen == 0; c++) begin
      @(negedge clock);
      if (rsp_valid) begin
        seen = c;
        check("timeout rsp_error", 32'(rsp_error), 32'd1);
        check("timeout rsp_rdata", rsp_rdata, 32'd0);
      end
    end
    check("timeout cycle", 32'(seen), 32'd6);
    @(negedge clock);
    check("post-timeout d_ready", 32'(tl_d_ready), 32'd1);
    check("post-timeout req_ready", 32'(req_ready), 32'd1);
    tld = '{d_valid: 1'b1, d_opcode: TL_ACK_DATA, d_source: SRC, d_error: 1'b0,
            d_data: 32'h7777_7777};
    @(posedge clock); #1;
    tld = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("late beat no rsp c%0d", c), 32'(rsp_valid), 32'd0);
    end

    // Reset in WAIT_D after a wrong-source beat.
    @(negedge clock);
    drive_req(1'b0, 32'h0000_0600, 2'd2, 32'h0);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    tl_a_ready = 1'b1;
    @(posedge clock); #1;
    tl_a_ready = 1'b0;
    tld = '{d_valid: 1'b1, d_opcode: TL_ACK_DATA, d_source: 8'd0, d_error: 1'b0,
            d_data: 32'h1234_5678};
    @(negedge clock);
    check("wrong-src d_ready", 32'(tl_d_ready), 32'd1);
    @(posedge clock); #1;
    tld = '0;
    @(negedge clock);
    check("wrong-src dropped", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mid reset req_ready", 32'(req_ready), 32'd1);
    check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid reset rsp_rdata", rsp_rdata, 32'd0);
    check("mid reset rsp_error", 32'(rsp_error), 32'd0);
    check("mid reset d_ready", 32'(tl_d_ready), 32'd1);
    check("mid reset tla zero", 32'(tla == '0), 32'd1);
    reset = 1'b0;
    tld = '{d_valid: 1'b1, d_opcode: TL_ACK_DATA, d_source: SRC, d_error: 1'b0,
            d_data: 32'h9999_9999};
    @(posedge clock); #1;
    tld = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check($sformatf("post reset no rsp c%0d", c), 32'(rsp_valid), 32'd0);
    end

    run_vec(vecs[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tilelink_host.md
Name: tilelink_host

Overview:
- Single-outstanding TileLink-UL initiator. Converts a simple CPU-side load/store request into an A-channel beat, then waits for the matching D-channel response.
- Drives tilelink_a toward memory responders such as the block RAM and consumes tilelink_d from them.
- Handles byte-lane mask generation, write-data lane placement, read-data extraction, misalignment rejection and response timeout.

Parameters:
- SOURCE_ID, 0, value driven on a_source; D beats with another d_source are discarded.
- TIMEOUT, 255, WAIT_D cycles before an error response is forced (8-bit counter; legal range 1..255).

Ports:
- clock  input  1  global clock.
- reset  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_write  input  1  1=store, 0=load.
- req_addr  input  32  byte address.
- req_size  input  2  0=byte, 1=half, 2=word; 3 is illegal.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load data, zero-extended; 0 for stores and errors.
- rsp_error  output  1  error flag, qualified by rsp_valid.
- tla  output  tilelink_a  A-channel (a_ready field driven 0).
- tl_a_ready  input  1  responder accepts A beat.
- tld  input  tilelink_d  D-channel from responder.
- tl_d_ready  output  1  host accepts D beat.

Behaviour:
- Interface is fixed: one clock, `clock`; reset is synchronous and active-high, `reset`.
- State machine states: IDLE, SEND_A, WAIT_D, RESP.
- Reset forces IDLE and clears all registers. Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, tl_d_ready=1.
  - All tla fields=0.
  - Reset mid-transaction abandons the transaction with no response. A later D beat is drained in IDLE.
- IDLE:
  - req_ready=1. Accept when req_valid.
  - Latch opcode, address, mask and placed data.
  - Legal request: go to SEND_A next cycle.
  - Misaligned request goes to RESP with error=1 and issues no bus beat. Misaligned means size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3.
- Encoding (bus address is req_addr with low bits kept):
  - Mask: size0 = 1<<addr[1:0]; size1 = 4'b0011<<(2*addr[1]); size2 = 4'hF.
  - Opcode: store with size2 = PutFullData(0); store with size0/1 = PutPartialData(1); load = Get(4).
  - a_size = req_size; a_param = 0.
  - Write data placed as req_wdata << (8*addr[1:0]).
- SEND_A:
  - a_valid=1 with fields stable until tl_a_ready is sampled high.
  - On acceptance go to WAIT_D, clear the timeout counter, drop a_valid next cycle.
  - No timeout in SEND_A.
- WAIT_D:
  - tl_d_ready=1; counter increments each cycle.
  - Beat with d_valid and d_source==SOURCE_ID: capture, go to RESP.
    - rdata = (d_data >> 8*addr[1:0]) masked to size, loads only.
    - error = d_error, or opcode mismatch: a load needs AccessAckData(1), a store needs AccessAck(0).
  - Beat with another source: consumed and dropped.
  - Counter reaches TIMEOUT with no match: go to RESP with error=1, rdata=0.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in SEND_A, WAIT_D and RESP, so back-to-back requests take at least one idle cycle.
- Latency, legal load with a zero-wait responder:
  - Cycle 0: accept.
  - Cycle 1: A beat.
  - Cycle 2: D beat.
  - Cycle 3: rsp_valid.
- Boundary conditions:
  - tl_d_ready=1 in IDLE, to drain stale D beats (for example after a timeout or a reset).
  - tl_d_ready=0 in SEND_A and RESP.
  - A D beat arriving in the same cycle as the A handshake is not accepted; the response must come later.

Decomposition:
- The tilelink package holds:
  - tilelink_a and tilelink_d typedefs.
  - Opcode constants: TL_PUT_FULL=0, TL_PUT_PARTIAL=1, TL_GET=4, TL_ACK=0, TL_ACK_DATA=1.
  - The state enum.
- One sub-module: tl_lane_align. This is combinational: size/address to mask, write-data shift, read-data extract and misalign flag. It is reused by other bus masters.

Test Plan:
1. Word store: addr=0x104, size2, wdata=0xDEADBEEF, zero-wait responder.
   - Required: opcode 0, mask 0xF, a_data 0xDEADBEEF.
   - Required: rsp_valid at cycle 3, error=0.
2. Byte load: addr=0x107, size0, responder returns d_data=0xAABBCCDD with opcode 1.
   - Required: Get with mask 0x8.
   - Required: rsp_rdata=0x000000AA.
3. Half store: addr=0x202, size1, wdata=0x1234, tl_a_ready held low 5 cycles.
   - Required: a_valid stable for 6 cycles, mask 0xC, a_data 0x12340000, opcode 1.
4. Misaligned word load: addr=0x101.
   - Required: no a_valid ever.
   - Required: rsp_valid 2 cycles after acceptance (RESP entered next cycle, pulse the cycle after), error=1, rdata=0.
5. TIMEOUT=4, responder silent.
   - Required: rsp_error=1 after 4 WAIT_D cycles.
   - Required: a late D beat is drained in IDLE and produces no rsp_valid.
6. Reset asserted while in WAIT_D, plus a D beat with the wrong source.
   - Required: reset returns IDLE with all outputs at reset values.
   - Required: the wrong-source beat is dropped and no response is produced.
